// File: rtl/seq_mult_ovf.sv
// Multi-cycle signed multiplier (radix-2 Booth, one step per clock) with
// overflow detection and optional saturation of the WIDTH-bit result.
module seq_mult_ovf #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic             qm1;
    logic [CW-1:0]    counter;

    logic             last_step_c;
    logic [WIDTH:0]   a_ext_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   hi_sh_c;
    logic [WIDTH-1:0] lo_sh_c;
    logic [PW-1:0]    product_c;
    logic             ovf_c;
    logic [WIDTH-1:0] sat_val_c;
    logic [WIDTH-1:0] result_c;

    assign last_step_c = (counter == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a start in DONE is accepted back-to-back
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ctrl_MULT) state_next = RUN;
            RUN:     if (last_step_c) state_next = DONE;
            DONE:    state_next = ctrl_MULT ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One Booth step, final product and overflow/saturation decode
    always_comb begin
        a_ext_c = {a_reg[WIDTH-1], a_reg};
        case ({lo[0], qm1})
            2'b01:   sum_c = hi + a_ext_c;
            2'b10:   sum_c = hi - a_ext_c;
            default: sum_c = hi;
        endcase
        hi_sh_c   = {sum_c[WIDTH], sum_c[WIDTH:1]};
        lo_sh_c   = {sum_c[0], lo[WIDTH-1:1]};
        product_c = {hi_sh_c[WIDTH-1:0], lo_sh_c};
        ovf_c     = !((&product_c[PW-1:WIDTH-1]) || !(|product_c[PW-1:WIDTH-1]));
        sat_val_c = product_c[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        result_c  = (SATURATE && ovf_c) ? sat_val_c : product_c[WIDTH-1:0];
    end

    // Datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg          <= '0;
            hi             <= '0;
            lo             <= '0;
            qm1            <= 1'b0;
            counter        <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            busy           <= (state_next == RUN);
            case (state)
                IDLE, DONE: begin
                    if (ctrl_MULT) begin
                        a_reg   <= data_operandA;
                        hi      <= '0;
                        lo      <= data_operandB;
                        qm1     <= 1'b0;
                        counter <= '0;
                    end
                end
                RUN: begin
                    hi      <= hi_sh_c;
                    lo      <= lo_sh_c;
                    qm1     <= lo[0];
                    counter <= counter + CW'(1);
                    if (last_step_c) begin
                        data_result    <= result_c;
                        data_exception <= ovf_c;
                        data_resultRDY <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ovf.sv
// Self-checking bench for seq_mult_ovf: 32-bit and 8-bit instances, wrap and
// saturate flavours, directed corner cases plus randomized operands.
module tb_seq_mult_ovf;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        start32, start8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;

    logic [31:0] r32w, r32s;
    logic        e32w, e32s, rdy32w, rdy32s, busy32w, busy32s;
    logic [7:0]  r8w, r8s;
    logic        e8w, e8s, rdy8w, rdy8s, busy8w, busy8s;

    int n_checks = 0;
    int n_pass   = 0;

    seq_mult_ovf #(.WIDTH(32), .SATURATE(1'b0)) u_w32 (
        .clock(clock), .reset(reset), .ctrl_MULT(start32),
        .data_operandA(a32), .data_operandB(b32),
        .data_result(r32w), .data_exception(e32w),
        .data_resultRDY(rdy32w), .busy(busy32w)
    );
    seq_mult_ovf #(.WIDTH(32), .SATURATE(1'b1)) u_s32 (
        .clock(clock), .reset(reset), .ctrl_MULT(start32),
        .data_operandA(a32), .data_operandB(b32),
        .data_result(r32s), .data_exception(e32s),
        .data_resultRDY(rdy32s), .busy(busy32s)
    );
    seq_mult_ovf #(.WIDTH(8), .SATURATE(1'b0)) u_w8 (
        .clock(clock), .reset(reset), .ctrl_MULT(start8),
        .data_operandA(a8), .data_operandB(b8),
        .data_result(r8w), .data_exception(e8w),
        .data_resultRDY(rdy8w), .busy(busy8w)
    );
    seq_mult_ovf #(.WIDTH(8), .SATURATE(1'b1)) u_s8 (
        .clock(clock), .reset(reset), .ctrl_MULT(start8),
        .data_operandA(a8), .data_operandB(b8),
        .data_result(r8s), .data_exception(e8s),
        .data_resultRDY(rdy8s), .busy(busy8s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Reference: exact signed product, then range test against WIDTH bits
    function automatic void model(input int w, input bit sat, input longint as,
                                  input longint bs, output logic [31:0] res,
                                  output logic ovf);
        longint p, mx, mn;
        logic [63:0] pv;
        p   = as * bs;
        mx  = (longint'(1) <<< (w - 1)) - 1;
        mn  = -mx - 1;
        ovf = (p > mx) || (p < mn);
        if (sat && ovf) p = (p < 0) ? mn : mx;
        pv  = p;
        res = (w == 32) ? pv[31:0] : {24'h0, pv[7:0]};
    endfunction

    task automatic start_op(input bit w8, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        if (w8) begin a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; end
        else    begin a32 = a;     b32 = b;     start32 = 1'b1; end
        @(posedge clock);
        #1;
        start8  = 1'b0;
        start32 = 1'b0;
    endtask

    // Count edges until RDY; busy must stay high until then
    task automatic wait_rdy(input bit w8, output int cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        while (!(w8 ? rdy8w : rdy32w) && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
            if (!(w8 ? rdy8w : rdy32w) && !(w8 ? busy8w : busy32w)) busy_ok = 1'b0;
        end
    endtask

    task automatic check_model(input bit w8, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ew, es;
        logic        ov, ov2;
        longint      as, bs;
        if (w8) begin
            as = longint'($signed(a[7:0]));
            bs = longint'($signed(b[7:0]));
            model(8, 1'b0, as, bs, ew, ov);
            model(8, 1'b1, as, bs, es, ov2);
            chk($sformatf("rnd8_wrap %0d*%0d", as, bs), {56'h0, r8w}, {32'h0, ew});
            chk($sformatf("rnd8_sat %0d*%0d", as, bs), {56'h0, r8s}, {32'h0, es});
            chk("rnd8_exc_wrap", {63'h0, e8w}, {63'h0, ov});
            chk("rnd8_exc_sat", {63'h0, e8s}, {63'h0, ov2});
        end else begin
            as = longint'($signed(a));
            bs = longint'($signed(b));
            model(32, 1'b0, as, bs, ew, ov);
            model(32, 1'b1, as, bs, es, ov2);
            chk($sformatf("rnd32_wrap %0d*%0d", as, bs), {32'h0, r32w}, {32'h0, ew});
            chk($sformatf("rnd32_sat %0d*%0d", as, bs), {32'h0, r32s}, {32'h0, es});
            chk("rnd32_exc_wrap", {63'h0, e32w}, {63'h0, ov});
            chk("rnd32_exc_sat", {63'h0, e32s}, {63'h0, ov2});
        end
    endtask

    typedef struct {
        logic [31:0] a, b, rw, rs;
        logic        e;
    } vec_t;

    vec_t d32[6];
    vec_t d8[4];

    initial begin
        int          cyc, cyc2;
        bit          bok;
        logic [31:0] ra, rb;

        d32[0] = '{32'd3,        32'hFFFF_FFFC, 32'hFFFF_FFF4, 32'hFFFF_FFF4, 1'b0};
        d32[1] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
        d32[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        d32[3] = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 1'b0};
        d32[4] = '{32'd65536,    32'hFFFF_8000, 32'h8000_0000, 32'h8000_0000, 1'b0};
        d32[5] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        d8[0]  = '{32'h10, 32'h08, 32'h80, 32'h7F, 1'b1};
        d8[1]  = '{32'hF0, 32'h08, 32'h80, 32'h80, 1'b0};
        d8[2]  = '{32'h80, 32'h80, 32'h00, 32'h7F, 1'b1};
        d8[3]  = '{32'h80, 32'hFF, 32'h80, 32'h7F, 1'b1};

        reset = 1'b1; start32 = 1'b0; start8 = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_result", {32'h0, r32w}, 64'h0);
        chk("rst_exc", {63'h0, e32w}, 64'h0);
        chk("rst_rdy", {63'h0, rdy32w}, 64'h0);
        chk("rst_busy", {63'h0, busy32w}, 64'h0);

        // Reset and start on the same edge: reset wins
        @(negedge clock);
        a32 = 32'd5; b32 = 32'd5; start32 = 1'b1;
        @(posedge clock);
        #1;
        start32 = 1'b0;
        chk("rst_vs_start_busy", {63'h0, busy32w}, 64'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_vs_start_idle", {63'h0, busy32w}, 64'h0);

        // Directed 32-bit corners
        foreach (d32[i]) begin
            start_op(1'b0, d32[i].a, d32[i].b);
            chk("busy_after_start", {63'h0, busy32w}, 64'h1);
            wait_rdy(1'b0, cyc, bok);
            chk("latency32", 64'(cyc), 64'd32);
            chk("busy_run32", {63'h0, bok}, 64'h1);
            chk("busy_done32", {63'h0, busy32w}, 64'h0);
            chk($sformatf("dir32_wrap_%0d", i), {32'h0, r32w}, {32'h0, d32[i].rw});
            chk($sformatf("dir32_sat_%0d", i), {32'h0, r32s}, {32'h0, d32[i].rs});
            chk($sformatf("dir32_exc_%0d", i), {63'h0, e32w}, {63'h0, d32[i].e});
            chk($sformatf("dir32_exc_sat_%0d", i), {63'h0, e32s}, {63'h0, d32[i].e});
            @(posedge clock);
            #1;
            chk("rdy_one_cycle", {63'h0, rdy32w}, 64'h0);
        end

        // Outputs hold after DONE
        repeat (3) @(posedge clock);
        #1;
        chk("hold_result", {32'h0, r32w}, {32'h0, d32[5].rw});

        // ctrl_MULT during RUN is ignored
        start_op(1'b0, 32'd1234, 32'hFFFF_FF00);
        repeat (5) @(posedge clock);
        @(negedge clock);
        a32 = 32'd77; b32 = 32'd99; start32 = 1'b1;
        @(posedge clock);
        #1;
        start32 = 1'b0;
        wait_rdy(1'b0, cyc, bok);
        chk("ignore_start_latency", 64'(cyc), 64'd26);
        chk("ignore_start_result", {32'h0, r32w}, {32'h0, 32'hFFFB_2E00});

        // Back-to-back start in the DONE cycle
        @(posedge clock);
        #1;
        start_op(1'b0, 32'd7, 32'd9);
        wait_rdy(1'b0, cyc, bok);
        chk("b2b_first_latency", 64'(cyc), 64'd32);
        chk("b2b_first_result", {32'h0, r32w}, 64'd63);
        a32 = 32'hFFFF_FFF9; b32 = 32'd11; start32 = 1'b1;
        @(posedge clock);
        #1;
        start32 = 1'b0;
        chk("b2b_rdy_drop", {63'h0, rdy32w}, 64'h0);
        wait_rdy(1'b0, cyc2, bok);
        chk("b2b_spacing", 64'(cyc2 + 1), 64'd33);
        chk("b2b_second_result", {32'h0, r32w}, {32'h0, 32'hFFFF_FFB3});

        // Reset in the middle of a run aborts it
        @(posedge clock);
        #1;
        start_op(1'b0, 32'd100, 32'd200);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("midrst_result", {32'h0, r32w}, 64'h0);
        chk("midrst_exc", {63'h0, e32w}, 64'h0);
        chk("midrst_busy", {63'h0, busy32w}, 64'h0);
        chk("midrst_rdy", {63'h0, rdy32w}, 64'h0);
        start_op(1'b0, 32'd300, 32'd5);
        wait_rdy(1'b0, cyc, bok);
        chk("midrst_restart_latency", 64'(cyc), 64'd32);
        chk("midrst_restart_result", {32'h0, r32w}, 64'd1500);

        // Randomized 32-bit operands with varied magnitudes
        repeat (20) begin
            ra = 32'($signed($urandom) >>> $urandom_range(0, 31));
            rb = 32'($signed($urandom) >>> $urandom_range(0, 31));
            @(posedge clock);
            #1;
            start_op(1'b0, ra, rb);
            wait_rdy(1'b0, cyc, bok);
            chk("rnd32_latency", 64'(cyc), 64'd32);
            check_model(1'b0, ra, rb);
        end

        // Directed 8-bit corners
        foreach (d8[i]) begin
            @(posedge clock);
            #1;
            start_op(1'b1, d8[i].a, d8[i].b);
            wait_rdy(1'b1, cyc, bok);
            chk("latency8", 64'(cyc), 64'd8);
            chk("busy_run8", {63'h0, bok}, 64'h1);
            chk($sformatf("dir8_wrap_%0d", i), {56'h0, r8w}, {32'h0, d8[i].rw});
            chk($sformatf("dir8_sat_%0d", i), {56'h0, r8s}, {32'h0, d8[i].rs});
            chk($sformatf("dir8_exc_%0d", i), {63'h0, e8w}, {63'h0, d8[i].e});
            chk($sformatf("dir8_exc_sat_%0d", i), {63'h0, e8s}, {63'h0, d8[i].e});
        end

        // Randomized 8-bit operands
        repeat (30) begin
            ra = 32'($urandom_range(0, 255));
            rb = 32'($urandom_range(0, 255));
            @(posedge clock);
            #1;
            start_op(1'b1, ra, rb);
            wait_rdy(1'b1, cyc, bok);
            chk("rnd8_latency", 64'(cyc), 64'd8);
            check_model(1'b1, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
